// File: rtl/simplified_circuit_pkg.sv
// Shared definitions for simplified_circuit: the canonical truth table,
// the 4-bit input index type and small helpers for building it.
// The optional self-check is enabled with SIMPLIFIED_CIRCUIT_CHECK_EN.
package simplified_circuit_pkg;

  // Number of input combinations of the 4-input function
  localparam int unsigned IDX_NUM = 16;

  // Canonical truth table: bit n is S for input index n = {X4,X3,X2,X1}
  // (minterms 1,3,4,9,10,11,14,15)
  localparam logic [IDX_NUM-1:0] TRUTH_TABLE = 16'hCE1A;

  // Index of one input combination
  typedef logic [3:0] idx_t;

  // One bit per input combination
  typedef logic [IDX_NUM-1:0] mask_t;

  // Pack the four function inputs into their index; X1 is the LSB
  function automatic idx_t idx_of(input logic x4, input logic x3,
                                  input logic x2, input logic x1);
    return {x4, x3, x2, x1};
  endfunction

  // One-hot mask with only bit idx set
  function automatic mask_t onehot(input idx_t idx);
    mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/simplified_circuit_logic.sv
// Purely combinational minimized sum-of-products for S(X1..X4).
// Shared by the registered evaluator and any gate-level comparison.
module simplified_circuit_logic (
  input  logic X1,
  input  logic X2,
  input  logic X3,
  input  logic X4,
  output logic S_comb
);

  // Three product terms of the minimized cover
  logic w_term_a;
  logic w_term_b;
  logic w_term_c;

  assign w_term_a = X1 & ~X3;               // minterms 1,3,9,11
  assign w_term_b = X2 & X4;                // minterms 10,11,14,15
  assign w_term_c = ~X4 & X3 & ~X2 & ~X1;   // minterm 4

  assign S_comb = w_term_a | w_term_b | w_term_c;

endmodule

// File: rtl/simplified_circuit.sv
// Registered evaluator for the minimized 4-input function S.
// Samples X1..X4 on in_valid, presents S one cycle later with a
// one-cycle out_valid pulse, and tracks which input indices have been
// applied. Defining SIMPLIFIED_CIRCUIT_CHECK_EN adds a checker that
// compares the SOP against the canonical truth table and exposes the
// mismatch/err_cnt ports and the CNT_W parameter.
module simplified_circuit
  import simplified_circuit_pkg::*;
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             X1,
  input  logic             X2,
  input  logic             X3,
  input  logic             X4,
  output logic             S,
  output logic             out_valid,
  output logic [15:0]      seen_mask,
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
  output logic             all_seen,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
`else
  output logic             all_seen
`endif
);

  // Current input combination and its minimized evaluation
  idx_t  w_idx;
  logic  w_s_comb;
  mask_t w_seen_next;

  logic  r_s;
  logic  r_out_valid;
  mask_t r_seen_mask;
  logic  r_all_seen;

  assign w_idx = idx_of(X4, X3, X2, X1);

  simplified_circuit_logic u_logic (
    .X1     (X1),
    .X2     (X2),
    .X3     (X3),
    .X4     (X4),
    .S_comb (w_s_comb)
  );

  // Next coverage mask: add the current index when a sample is accepted
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_seen_next = r_seen_mask;
    if (in_valid) begin
      w_seen_next = r_seen_mask | onehot(w_idx);
    end
  end

  // Result register: capture the SOP on accepted samples, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s <= w_s_comb;
      end
    end
  end

  // Coverage registers: sticky mask and its full-coverage flag, same edge as S
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the 16-bit mask is plain flops, so it is reset like any control state.
      r_seen_mask <= '0;
      r_all_seen  <= 1'b0;
    end else begin
      r_seen_mask <= w_seen_next;
      r_all_seen  <= &w_seen_next;
    end
  end

  assign S         = r_s;
  assign out_valid = r_out_valid;
  assign seen_mask = r_seen_mask;
  assign all_seen  = r_all_seen;

`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
  // Reference bit from the canonical table and the per-sample inequality
  logic             w_tt_bit;
  logic             w_mismatch;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_tt_bit   = TRUTH_TABLE[w_idx];
  assign w_mismatch = in_valid & (w_s_comb != w_tt_bit);

  // Checker registers: mismatch flag aligned with S, saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_mismatch <= w_mismatch;
      if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign mismatch = r_mismatch;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_simplified_circuit.sv
// Self-checking bench for simplified_circuit. Table-driven sweep, hand
// sequences for hold/reset/coverage corners, and randomized traffic
// against a minterm-list reference model. Checker tests are compiled
// when SIMPLIFIED_CIRCUIT_CHECK_EN is defined.
module tb_simplified_circuit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        X1, X2, X3, X4;
  logic        S;
  logic        out_valid;
  logic [15:0] seen_mask;
  logic        all_seen;
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
  logic        mismatch;
  logic [7:0]  err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit clk_en   = 0;

`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
  simplified_circuit #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .S(S), .out_valid(out_valid), .seen_mask(seen_mask), .all_seen(all_seen),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );
`else
  simplified_circuit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .S(S), .out_valid(out_valid), .seen_mask(seen_mask), .all_seen(all_seen)
  );
`endif

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Reference: S is true exactly on these minterms
  int minterms[8] = '{1, 3, 4, 9, 10, 11, 14, 15};

  function automatic logic model_s(input int n);
    foreach (minterms[i]) if (minterms[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    int   n;
    logic exp_s;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and return #1 after the capturing edge
  task automatic apply(input logic v, input int n);
    logic [3:0] nb;
    nb       = n[3:0];
    in_valid = v;
    {X4, X3, X2, X1} = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  vec_t sweep[16];

  initial begin
    logic [15:0] exp_seen;
    logic        exp_s;
    logic        v;
    int          n;

    // Sweep table: expected S per index from the requirement list
    begin
      logic [15:0] seq;
      seq = 16'b1100_1110_0001_1010;
      for (int i = 0; i < 16; i++) begin
        sweep[i].n     = i;
        sweep[i].exp_s = seq[i];
      end
    end

    // Reset with no clock running
    in_valid = 1'b0;
    {X4, X3, X2, X1} = 4'h0;
    rst_n = 1'b0;
    #3;
    check("reset_S", S, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_seen_mask", seen_mask, 16'h0000);
    check("reset_all_seen", all_seen, 0);
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
    check("reset_err_cnt", err_cnt, 0);
    check("reset_mismatch", mismatch, 0);
`endif
    #2;
    rst_n  = 1'b1;
    #1;
    clk_en = 1;
    @(posedge clk);
    #1;

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, sweep[i].n);
      check($sformatf("sweep_S[%0d]", i), S, sweep[i].exp_s);
      check($sformatf("sweep_model[%0d]", i), S, model_s(i));
      check($sformatf("sweep_ov[%0d]", i), out_valid, 1);
      check($sformatf("sweep_all_seen[%0d]", i), all_seen, (i == 15));
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
      check($sformatf("sweep_mismatch[%0d]", i), mismatch, 0);
`endif
    end
    check("sweep_seen_mask", seen_mask, 16'hFFFF);
`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
    check("sweep_err_cnt", err_cnt, 0);
`endif

    // Hold: S=1 from n=4 then three idle cycles with n=0
    apply(1'b1, 4);
    check("hold_load_S", S, 1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 0);
      check($sformatf("hold_S[%0d]", i), S, 1);
      check($sformatf("hold_ov[%0d]", i), out_valid, 0);
    end

    // Reset mid-stream after sampling n=9
    pulse_reset();
    apply(1'b1, 9);
    check("mid_pre_S", S, 1);
    in_valid = 1'b1;
    {X4, X3, X2, X1} = 4'd5;
    rst_n = 1'b0;
    #2;
    check("mid_rst_S", S, 0);
    check("mid_rst_seen", seen_mask, 16'h0000);
    check("mid_rst_ov", out_valid, 0);
    rst_n = 1'b1;
    apply(1'b1, 10);
    check("mid_after_S", S, 1);
    check("mid_after_seen", seen_mask, 16'h0400);
    check("mid_after_all_seen", all_seen, 0);

    // Partial coverage
    pulse_reset();
    apply(1'b1, 1);
    apply(1'b1, 3);
    apply(1'b1, 9);
    apply(1'b1, 11);
    apply(1'b0, 0);
    check("partial_seen", seen_mask, 16'h0A0A);
    check("partial_all_seen", all_seen, 0);

    // Randomized traffic against the reference model
    pulse_reset();
    exp_seen = '0;
    exp_s    = 1'b0;
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, 15);
      apply(v, n);
      if (v) begin
        exp_s = model_s(n);
        exp_seen[n] = 1'b1;
      end
      check("rand_S", S, exp_s);
      check("rand_ov", out_valid, v);
      check("rand_seen", seen_mask, exp_seen);
      check("rand_all_seen", all_seen, (exp_seen == 16'hFFFF));
    end

`ifdef SIMPLIFIED_CIRCUIT_CHECK_EN
    // Corrupt the SOP at n=2 and drive it 300 times: counter saturates
    pulse_reset();
    force u_dut.w_s_comb = 1'b1;
    apply(1'b1, 2);
    check("force_mismatch", mismatch, 1);
    check("force_err_first", err_cnt, 1);
    for (int i = 1; i < 300; i++) apply(1'b1, 2);
    check("force_err_sat", err_cnt, 255);
    apply(1'b0, 2);
    check("force_mismatch_idle", mismatch, 0);
    check("force_err_hold", err_cnt, 255);
    release u_dut.w_s_comb;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
